// File: rtl/qs_sched_pkg.sv
// Shared definitions for the queue scheduler: FSM encoding, queue indices
// and the location of the token-cost field inside q2 metadata.
package qs_sched_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  localparam logic [1:0] Q_TSN_EVEN = 2'd0;
  localparam logic [1:0] Q_TSN_ODD  = 2'd1;
  localparam logic [1:0] Q_BR       = 2'd2;
  localparam logic [1:0] Q_BE       = 2'd3;

  localparam int MD_W    = 9;
  localparam int COST_HI = 19;
  localparam int COST_LO = 9;
  localparam int COST_W  = COST_HI - COST_LO + 1;
endpackage

// File: rtl/qs_token_bucket.sv
// Token bucket for the rate-limited queue: periodic tick, saturating refill,
// cost deduction on grant, and clamping whenever the bucket limit shrinks.
module qs_token_bucket
  import qs_sched_pkg::*;
#(
  parameter int TOKEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rate_i,
  input  logic [15:0]        period_i,
  input  logic [TOKEN_W-1:0] bmax_i,
  input  logic [COST_W-1:0]  cost_i,
  input  logic               consume_i,
  output logic               afford_o,
  output logic [TOKEN_W-1:0] tokens_o
);
  // Headroom so subtract-then-add never wraps before the saturation compare.
  localparam int EW = ((TOKEN_W > COST_W) ? TOKEN_W : COST_W) + 2;

  logic [15:0]        cnt_q, cnt_d, last;
  logic               tick;
  logic [EW-1:0]      tok_w, cost_w, sum_w;
  logic [TOKEN_W-1:0] tok_q, tok_d;

  // Period 0 behaves as period 1; >= keeps a shortened period from stalling.
  assign last  = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
  assign tick  = (cnt_q >= last);
  assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

  assign tok_w    = EW'(tok_q);
  assign cost_w   = EW'(cost_i);
  assign afford_o = (cost_i == '0) || (tok_w >= cost_w);
  assign tokens_o = tok_q;

  always_comb begin
    sum_w = tok_w - (consume_i ? cost_w : '0) + (tick ? EW'(rate_i) : '0);
    tok_d = (sum_w > EW'(bmax_i)) ? bmax_i : sum_w[TOKEN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tok_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tok_q <= tok_d;
    end
  end
endmodule

// File: rtl/qs_sched.sv
// Four-queue egress scheduler: slot-gated TSN queue > token-bucket queue >
// best effort, one packet in flight until the transmit stage reports done.
module qs_sched
  import qs_sched_pkg::*;
#(
  parameter int TOKEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_time_slot_flag,
  input  logic [8:0]         q0_md,
  input  logic [8:0]         q1_md,
  input  logic [19:0]        q2_md,
  input  logic [8:0]         q3_md,
  input  logic               q0_empty,
  input  logic               q1_empty,
  input  logic               q2_empty,
  input  logic               q3_empty,
  output logic               q0_rd,
  output logic               q1_rd,
  output logic               q2_rd,
  output logic               q3_rd,
  output logic [8:0]         out_md,
  output logic [1:0]         out_qid,
  output logic               out_md_wr,
  input  logic               in_tx_done,
  input  logic [7:0]         cfg_token_rate,
  input  logic [15:0]        cfg_token_period,
  input  logic [TOKEN_W-1:0] cfg_bucket_max
);
  state_e            state_q;
  logic [3:0]        rd_q;
  logic              wr_q;
  logic [MD_W-1:0]   md_q;
  logic [1:0]        qid_q;

  logic              afford, tsn_ok, win_vld, consume;
  logic [1:0]        win_qid;
  logic [MD_W-1:0]   win_md;
  logic [TOKEN_W-1:0] tokens;

  // flag=1 serves q0, flag=0 serves q1; the other TSN queue is never eligible.
  always_comb begin
    tsn_ok  = in_time_slot_flag ? !q0_empty : !q1_empty;
    win_vld = 1'b1;
    win_qid = Q_BE;
    win_md  = q3_md;
    if (tsn_ok) begin
      win_qid = in_time_slot_flag ? Q_TSN_EVEN : Q_TSN_ODD;
      win_md  = in_time_slot_flag ? q0_md : q1_md;
    end else if (!q2_empty && afford) begin
      win_qid = Q_BR;
      win_md  = q2_md[MD_W-1:0];
    end else if (q3_empty) begin
      win_vld = 1'b0;
    end
  end

  assign consume = (state_q == ST_IDLE) && win_vld && (win_qid == Q_BR);

  qs_token_bucket #(.TOKEN_W(TOKEN_W)) u_bucket (
    .clk       (clk),
    .rst_n     (rst_n),
    .rate_i    (cfg_token_rate),
    .period_i  (cfg_token_period),
    .bmax_i    (cfg_bucket_max),
    .cost_i    (q2_md[COST_HI:COST_LO]),
    .consume_i (consume),
    .afford_o  (afford),
    .tokens_o  (tokens)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      md_q    <= '0;
      qid_q   <= '0;
    end else begin
      rd_q <= '0;
      wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (win_vld) begin
          state_q <= ST_BUSY;
          wr_q    <= 1'b1;
          rd_q    <= 4'b0001 << win_qid;
          md_q    <= win_md;
          qid_q   <= win_qid;
        end
        ST_BUSY: if (in_tx_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {q3_rd, q2_rd, q1_rd, q0_rd} = rd_q;
  assign out_md_wr = wr_q;
  assign out_md    = md_q;
  assign out_qid   = qid_q;
endmodule

// File: tb/tb_qs_sched.sv
// Bench for qs_sched: cycle-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_qs_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag, done;
  logic [8:0]  q0_md, q1_md, q3_md;
  logic [19:0] q2_md;
  logic        q0_empty, q1_empty, q2_empty, q3_empty;
  logic        q0_rd, q1_rd, q2_rd, q3_rd;
  logic [8:0]  out_md;
  logic [1:0]  out_qid;
  logic        out_md_wr;
  logic [7:0]  rate;
  logic [15:0] period;
  logic [15:0] bmax;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qs_sched #(.TOKEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_time_slot_flag(flag),
    .q0_md(q0_md), .q1_md(q1_md), .q2_md(q2_md), .q3_md(q3_md),
    .q0_empty(q0_empty), .q1_empty(q1_empty), .q2_empty(q2_empty), .q3_empty(q3_empty),
    .q0_rd(q0_rd), .q1_rd(q1_rd), .q2_rd(q2_rd), .q3_rd(q3_rd),
    .out_md(out_md), .out_qid(out_qid), .out_md_wr(out_md_wr),
    .in_tx_done(done), .cfg_token_rate(rate), .cfg_token_period(period),
    .cfg_bucket_max(bmax)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: one packet in flight, priority by rule, bucket as an integer.
  bit         m_busy = 1'b0;
  int         m_tok = 0;
  int         m_cnt = 0;
  logic       e_wr = 1'b0;
  logic [3:0] e_rd = 4'b0;
  logic [8:0] e_md = 9'd0;
  logic [1:0] e_qid = 2'd0;

  always @(posedge clk or negedge rst_n) begin : model
    int win, cost, pe, nt, nc;
    if (!rst_n) begin
      m_busy <= 1'b0; m_tok <= 0; m_cnt <= 0;
      e_wr <= 1'b0; e_rd <= 4'b0; e_md <= 9'd0; e_qid <= 2'd0;
    end else begin
      win  = -1;
      cost = int'(q2_md[19:9]);
      pe   = (period == 16'd0) ? 1 : int'(period);
      if (!m_busy) begin
        if (flag ? !q0_empty : !q1_empty) win = flag ? 0 : 1;
        else if (!q2_empty && (cost == 0 || m_tok >= cost)) win = 2;
        else if (!q3_empty) win = 3;
      end
      nt = m_tok - ((win == 2) ? cost : 0);
      nc = m_cnt + 1;
      if (nc >= pe) begin nc = 0; nt = nt + int'(rate); end
      if (nt > int'(bmax)) nt = int'(bmax);
      m_tok <= nt;
      m_cnt <= nc;
      e_wr  <= (win >= 0);
      e_rd  <= (win >= 0) ? 4'(1 << win) : 4'b0;
      if (win >= 0) begin
        e_qid  <= 2'(win);
        e_md   <= (win == 0) ? q0_md : (win == 1) ? q1_md : (win == 2) ? q2_md[8:0] : q3_md;
        m_busy <= 1'b1;
      end else if (m_busy && done) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("wr",     32'(out_md_wr), 32'(e_wr));
    check("rd",     32'({q3_rd, q2_rd, q1_rd, q0_rd}), 32'(e_rd));
    check("md",     32'(out_md), 32'(e_md));
    check("qid",    32'(out_qid), 32'(e_qid));
    check("tokens", 32'(dut.u_bucket.tokens_o), 32'(m_tok));
  end

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Waits for a grant pulse; cycles = negedges elapsed, 0 on timeout.
  task automatic wait_grant(input int limit, output int cycles);
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (out_md_wr === 1'b1) begin
        cycles = i + 1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL grant_timeout waited=%0d cycles, required a grant", limit);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    rst_n = 1'b0; flag = 1'b0; done = 1'b0;
    q0_md = 9'h0AA; q1_md = 9'h011; q2_md = 20'd0; q3_md = 9'h033;
    q0_empty = 1'b1; q1_empty = 1'b1; q2_empty = 1'b1; q3_empty = 1'b1;
    rate = 8'd0; period = 16'd10; bmax = 16'd64;
    repeat (3) @(negedge clk);
    check("rst_wr",  32'(out_md_wr), 32'd0);
    check("rst_rd",  32'({q3_rd, q2_rd, q1_rd, q0_rd}), 32'd0);
    check("rst_tok", 32'(dut.u_bucket.tokens_o), 32'd0);

    // Slot gating: flag=0 serves q1 only.
    q0_empty = 1'b0; q1_empty = 1'b0;
    rst_n = 1'b1;
    wait_grant(4, cyc);
    check("slot_lat", 32'(cyc), 32'd1);
    check("slot_qid", 32'(out_qid), 32'd1);
    check("slot_md",  32'(out_md), 32'h011);
    check("slot_rd",  32'({q3_rd, q2_rd, q1_rd, q0_rd}), 32'b0010);
    q1_empty = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("slot_no_q0", 32'(out_md_wr), 32'd0);
    end
    // Flag flip while busy must not disturb the in-flight packet.
    q1_empty = 1'b0; q1_md = 9'h015;
    wait_grant(4, cyc);
    check("flag_busy_md", 32'(out_md), 32'h015);
    q1_empty = 1'b1; flag = 1'b1;
    repeat (3) @(negedge clk);
    check("flag_busy_qid", 32'(out_qid), 32'd1);

    // Strict priority with flag=1: q0, then q2 (cost 0), then q3.
    q0_md = 9'h1F0; q2_md = {11'd0, 9'h122}; q2_empty = 1'b0; q3_empty = 1'b0;
    pulse_done();
    wait_grant(4, cyc);
    check("prio0_lat", 32'(cyc), 32'd1);
    check("prio0_qid", 32'(out_qid), 32'd0);
    check("prio0_md",  32'(out_md), 32'h1F0);
    q0_empty = 1'b1;
    pulse_done();
    wait_grant(4, cyc);
    check("prio1_qid", 32'(out_qid), 32'd2);
    check("prio1_md",  32'(out_md), 32'h122);
    q2_empty = 1'b1;
    pulse_done();
    wait_grant(4, cyc);
    check("prio2_qid", 32'(out_qid), 32'd3);
    check("prio2_md",  32'(out_md), 32'h033);

    // Reset mid-BUSY: outputs drop asynchronously, grant resumes 1 cycle after release.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstb_wr",  32'(out_md_wr), 32'd0);
    check("rstb_qid", 32'(out_qid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(4, cyc);
    check("rstb_lat", 32'(cyc), 32'd1);
    check("rstb_rd",  32'({q3_rd, q2_rd, q1_rd, q0_rd}), 32'b1000);
    q3_empty = 1'b1;
    pulse_done();

    // Token gating: rate 4 every 10 cycles, cost 20 -> 5 ticks before grant.
    do_reset();
    period = 16'd10; rate = 8'd4; bmax = 16'd64;
    q2_md = {11'd20, 9'h0C2}; q2_empty = 1'b0;
    rst_n = 1'b1;
    wait_grant(80, cyc);
    check("tok_lat", 32'(cyc), 32'd51);
    check("tok_qid", 32'(out_qid), 32'd2);
    check("tok_after", 32'(dut.u_bucket.tokens_o), 32'd0);
    q2_empty = 1'b1;
    pulse_done();

    // Saturation, then a shrinking bucket clamps next cycle.
    period = 16'd2; rate = 8'd8;
    repeat (40) @(negedge clk);
    check("sat_tok", 32'(dut.u_bucket.tokens_o), 32'd64);
    bmax = 16'd30;
    @(negedge clk);
    check("clamp_tok", 32'(dut.u_bucket.tokens_o), 32'd30);

    // Tick and grant on the same edge: 20 - 20 + 4.
    do_reset();
    period = 16'd1; rate = 8'd4; bmax = 16'd64;
    q2_md = {11'd20, 9'h0D2}; q2_empty = 1'b0;
    rst_n = 1'b1;
    wait_grant(20, cyc);
    check("simul_lat", 32'(cyc), 32'd6);
    check("simul_tok", 32'(dut.u_bucket.tokens_o), 32'd4);
    q2_empty = 1'b1;
    pulse_done();

    // Done while idle is ignored; period 0 behaves as period 1.
    period = 16'd0; rate = 8'd1;
    pulse_done();
    repeat (4) @(negedge clk);
    q3_md = 9'h1A5; q3_empty = 1'b0;
    wait_grant(4, cyc);
    check("idle_done_lat", 32'(cyc), 32'd1);
    check("idle_done_md",  32'(out_md), 32'h1A5);
    q3_empty = 1'b1;
    pulse_done();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
